// File: rtl/mk_design_pkg.sv
// Shared definitions for the mk_design_param operand pipeline.
// MK_DESIGN_PARAM_SAT_EN selects a saturating start sum instead of a wrapping one.
package mk_design_pkg;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNTW  = $clog2(DEF_DEPTH + 1);

    // Widest operand the sum helper supports.
    localparam int SUM_MAXW  = 64;

    typedef logic [DEF_CNTW-1:0] occ_t;

    // Adds two operands of w significant bits and either wraps modulo 2^w or
    // clamps to all-ones on carry-out.
    function automatic logic [SUM_MAXW-1:0] sum_op(
        input logic [SUM_MAXW-1:0] a,
        input logic [SUM_MAXW-1:0] b,
        input int                  w
    );
        logic [SUM_MAXW:0] s;
        logic [SUM_MAXW:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ((SUM_MAXW+1)'(1) << w) - (SUM_MAXW+1)'(1);
`ifdef MK_DESIGN_PARAM_SAT_EN
        if (s > lim) begin
            s = lim;
        end
`endif
        return SUM_MAXW'(s & lim);
    endfunction

endpackage

// File: rtl/mk_design_fifo.sv
// Parametrised circular buffer holding queued sums for mk_design_param.
// Head is a non-destructive read of the oldest entry.
module mk_design_fifo
    import mk_design_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] head,
    output logic [CNTW-1:0]  occ,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_enq;
    logic             do_deq;

    assign full   = (occ == CNTW'(DEPTH));
    assign empty  = (occ == '0);
    assign do_deq = deq & ~empty;
    // A full buffer can still accept a write when the head leaves on the same edge.
    assign do_enq = enq & (~full | do_deq);
    assign head   = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap through natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_enq, do_deq})
                2'b10:   occ <= occ + CNTW'(1);
                2'b01:   occ <= occ - CNTW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

endmodule

// File: rtl/mk_design_param.sv
// Width/depth-configurable operand pipeline: start registers a sum, FIFO queues it,
// result peeks and check pops. MK_DESIGN_PARAM_SAT_EN makes the start sum saturate.
module mk_design_param
    import mk_design_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] start_a,
    input  logic [WIDTH-1:0] start_b,
    input  logic             STenable,
    output logic             RDY_start,
    input  logic [WIDTH-1:0] result_c,
    output logic [WIDTH-1:0] result,
    output logic             RDY_result,
    input  logic [WIDTH-1:0] check_d,
    input  logic             CHenable,
    output logic [WIDTH-1:0] check,
    output logic             RDY_check,
    output logic [CNTW-1:0]  count
);

    logic             rst_done;
    logic [WIDTH-1:0] stg;
    logic             stg_v;
    logic [WIDTH-1:0] stg_sum;
    logic             start_fire;
    logic             check_fire;
    logic             non_empty;
    logic [WIDTH-1:0] head;
    logic [CNTW-1:0]  occ;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNTW-1:0]  count_w;

    assign stg_sum = WIDTH'(sum_op(SUM_MAXW'(start_a), SUM_MAXW'(start_b), WIDTH));

    // Readiness comes from registered state only; a pop on this edge frees
    // its slot for start one cycle later.
    assign count_w    = occ + CNTW'(stg_v);
    assign RDY_start  = rst_done & ~fifo_full & (count_w < CNTW'(DEPTH));
    assign non_empty  = rst_done & ~fifo_empty;
    assign start_fire = STenable & RDY_start;
    assign check_fire = CHenable & non_empty;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_done <= 1'b0;
            stg      <= '0;
            stg_v    <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            stg_v    <= start_fire;
            if (start_fire) begin
                stg <= stg_sum;
            end
        end
    end

    // A valid stage entry always moves on: either pushed out by a new start
    // or drained when start is idle.
    mk_design_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .enq      (stg_v),
        .enq_data (stg),
        .deq      (check_fire),
        .head     (head),
        .occ      (occ),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign RDY_result = non_empty;
    assign RDY_check  = non_empty;
    assign result     = non_empty ? (head + result_c) : '0;
    assign check      = non_empty ? (head ^ check_d) : '0;
    assign count      = count_w;

endmodule

// File: doc/mk_design_param.md
# mk_design_param

Parametrised successor to the fixed 6-bit start/result/check design: a width- and depth-configurable operand pipeline. `start` accepts an operand pair and registers its sum. The sum then enters a DEPTH-entry FIFO. `result` is a non-destructive peek at the FIFO head. `check` pops the head. The block sits behind the port-renaming enable-test harness and keeps the same renamed enable ports, so existing benches scale to wider and deeper configurations.

## Interface
- WIDTH, 6, operand/result bit width (≥2)
- DEPTH, 4, FIFO entries (≥2, power of two)
- CNTW, $clog2(DEPTH+1), occupancy counter width
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- start_a  in  WIDTH  operand A
- start_b  in  WIDTH  operand B
- STenable  in  1  start enable; honoured only while RDY_start=1
- RDY_start  out  1  start may fire
- result_c  in  WIDTH  peek offset
- result  out  WIDTH  head + result_c (mod 2^WIDTH); 0 when RDY_result=0
- RDY_result  out  1  FIFO non-empty
- check_d  in  WIDTH  check mask
- CHenable  in  1  check enable (pops head); honoured only while RDY_check=1
- check  out  WIDTH  head ^ check_d; 0 when RDY_check=0
- RDY_check  out  1  FIFO non-empty
- count  out  CNTW  FIFO occupancy plus stage-register valid

## Operation
- Stage register `stg` (WIDTH bits) and `stg_v` flag, then a circular FIFO with rd_ptr, wr_ptr and occ counter.
- start fires when STenable & RDY_start:
  - stg ← start_a + start_b, truncated to WIDTH (wraps), and stg_v ← 1.
  - If stg_v was already set, the old stg moves into the FIFO on the same edge.
- Drain: when stg_v=1 and start does not fire, stg moves into the FIFO and stg_v ← 0.
- RDY_start = rst_done & (occ + stg_v < DEPTH). Computed from registered state only; no bypass from a same-cycle pop.
- check fires when CHenable & RDY_check: rd_ptr advances and occ decrements.
- Enables asserted while the matching RDY is low are ignored, with no state change.
- Same-cycle enqueue and pop: occ is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- count = occ + stg_v.
- Reset:
  - occ, pointers, stg, stg_v and rst_done are 0.
  - All RDY_* outputs are 0, and result/check/count are 0.
  - rst_done sets on the first rising CLK edge after RST_N deasserts.
- Reset asserted mid-operation clears all of the above immediately and discards all queued data.

## Timing
- start sampled at edge t: stg is valid after t. The entry is in the FIFO after t+1, so RDY_result is high in cycle t+2.
- Minimum start-to-result latency is 2 cycles.
- Sustained throughput is 1 start/cycle while space remains.
- result and check are combinational from the head register and the current inputs, with no added latency.
- Pop at edge t: the new head is visible in cycle t+1. RDY_start reflects the freed slot in cycle t+1.
- Full condition: occ + stg_v = DEPTH forces RDY_start=0 until a check fires.

## Configuration
- MK_DESIGN_PARAM_SAT_EN defined: the start sum saturates to all-ones on carry-out. For example, WIDTH=6 with a=40, b=40 gives 63.
- Undefined: the start sum wraps modulo 2^WIDTH (40+40 gives 16).
- result_c addition wraps in both builds.

## Structure
- Shared package mk_design_pkg:
  - default WIDTH/DEPTH localparams
  - a typedef for the occupancy type
  - a function `sum_op` that wraps or saturates according to the macro
- One sub-module, mk_design_fifo: a parametrised circular buffer with enq, deq, head, occ and full/empty.
- The top level holds the stage register, the RDY logic and the method muxing.

## Test plan
All scenarios use WIDTH=6, DEPTH=4.
1. Reset release: hold RST_N=0 for 3 cycles, then release.
   - All RDY and data outputs are 0 during reset.
   - RDY_start=1 in the first cycle after the first post-release edge; count=0.
2. Single op: start a=5, b=9. Two cycles later, check:
   - RDY_result=1 and result_c=1 → result=15.
   - check_d=6'h0F with CHenable → check=1; next cycle RDY_check=0.
3. Fill: start 5 consecutive cycles (a=i, b=1).
   - RDY_start drops once count=4; the fifth enable is ignored.
   - Popping returns heads 1, 2, 3, 4 in order.
4. Simultaneous: at count=2, assert start and check on the same edge. count stays 2 and FIFO order is preserved.
5. Overflow arithmetic: a=40, b=40 → head 16, or 63 with MK_DESIGN_PARAM_SAT_EN. Then result_c=63 wraps the result.
6. Mid-operation reset: with count=3, pulse RST_N low between edges.
   - All outputs go to 0 immediately.
   - After release, the queue is empty.
